// File: rtl/csrprot_pkg.sv
// Shared definitions for the serial CSR protocol: FSM encoding, field widths
// and the write flag carried in the address byte.
package csrprot_pkg;

    localparam int CSR_ADR_W = 7;
    localparam int CSR_DAT_W = 8;
    localparam logic [7:0] CSR_WRITE_FLAG = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_ADDR  = 3'd1,
        S_GAP_A    = 3'd2,
        S_TX_DATA  = 3'd3,
        S_GAP_D    = 3'd4,
        S_WAIT_RSP = 3'd5,
        S_RESP     = 3'd6
    } csr_state_t;

    function automatic logic [7:0] addr_byte(input logic we, input logic [CSR_ADR_W-1:0] adr);
        return (we ? CSR_WRITE_FLAG : 8'h00) | {1'b0, adr};
    endfunction

endpackage

// File: rtl/csr_serial_master_serial.sv
// Byte UART (8N1, LSB first) used as the CSR link transport. A received byte
// raises ready until ready_rst; a new byte arriving on the same cycle wins.
module serial #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] dat_t,
    input  logic       txe,
    output logic [7:0] dat_r,
    output logic       ready,
    input  logic       ready_rst
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2);

    logic             tx_q, tx_d;
    logic             tx_busy_q, tx_busy_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bits_q, tx_bits_d;
    logic [8:0]       tx_sh_q, tx_sh_d;

    logic             rx_meta_q, rx_sync_q;
    logic             rx_busy_q, rx_busy_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       dat_r_q, dat_r_d;
    logic             ready_q, ready_d;

    always_comb begin
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bits_d = tx_bits_q;
        tx_sh_d   = tx_sh_q;
        if (!tx_busy_q) begin
            if (txe) begin
                tx_sh_d   = {1'b1, dat_t};
                tx_d      = 1'b0;
                tx_bits_d = 4'd9;
                tx_cnt_d  = CNT_LOAD;
                tx_busy_d = 1'b1;
            end
        end else if (tx_cnt_q == '0) begin
            tx_cnt_d = CNT_LOAD;
            if (tx_bits_q == 4'd0) begin
                tx_busy_d = 1'b0;
            end else begin
                tx_d      = tx_sh_q[0];
                tx_sh_d   = {1'b0, tx_sh_q[8:1]};
                tx_bits_d = tx_bits_q - 4'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
    end

    // bit 0 is the start-bit check at mid-bit, 1..8 data, 9 the stop bit
    always_comb begin
        rx_busy_d = rx_busy_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        dat_r_d   = dat_r_q;
        ready_d   = ready_q & ~ready_rst;
        if (!rx_busy_q) begin
            if (!rx_sync_q) begin
                rx_busy_d = 1'b1;
                rx_bit_d  = 4'd0;
                rx_cnt_d  = HALF_LOAD;
            end
        end else if (rx_cnt_q == '0) begin
            rx_cnt_d = CNT_LOAD;
            if (rx_bit_q == 4'd0) begin
                if (rx_sync_q) rx_busy_d = 1'b0;
                else           rx_bit_d  = 4'd1;
            end else if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                if (rx_sync_q) begin
                    ready_d = 1'b1;
                    dat_r_d = rx_sh_q;
                end
            end else begin
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 4'd1;
            end
        end else begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bits_q <= '0;
            tx_sh_q   <= '0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_busy_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            dat_r_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bits_q <= tx_bits_d;
            tx_sh_q   <= tx_sh_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_busy_q <= rx_busy_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            dat_r_q   <= dat_r_d;
            ready_q   <= ready_d;
        end
    end

    assign tx    = tx_q;
    assign dat_r = dat_r_q;
    assign ready = ready_q;

endmodule

// File: rtl/csr_serial_master.sv
// Serial CSR initiator: one read/write command at a time, framed over the
// serial UART, one-byte reply. Optional reply timeout: CSR_SERIAL_MASTER_TIMEOUT_EN.
module csr_serial_master
    import csrprot_pkg::*;
#(
    parameter int TX_GAP      = 1100,
    parameter int RSP_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_rx,
    output logic                 serial_tx,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [CSR_ADR_W-1:0] cmd_adr,
    input  logic [CSR_DAT_W-1:0] cmd_dat_w,
    output logic                 rsp_valid,
    output logic [CSR_DAT_W-1:0] rsp_dat,
    output logic                 rsp_err,
    output logic                 busy
);

    // The byte gap must cover one 10-bit frame, so the bit time is derived from it.
    localparam int CLKS_PER_BIT = (TX_GAP / 11 > 0) ? TX_GAP / 11 : 1;
    localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP - 1);

    csr_state_t           state_q, state_d;
    logic                 we_q, we_d;
    logic [CSR_ADR_W-1:0] adr_q, adr_d;
    logic [CSR_DAT_W-1:0] dat_w_q, dat_w_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [7:0]           dat_t_q, dat_t_d;
    logic                 txe_q, txe_d;
    logic                 ready_rst_q, ready_rst_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CSR_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;
    logic [7:0]           dat_r;
    logic                 ready;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(RSP_TIMEOUT);
    logic [15:0]          to_q, to_d;
`endif

    serial #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serial (
        .clk      (clk),
        .rst      (rst),
        .rx       (serial_rx),
        .tx       (serial_tx),
        .dat_t    (dat_t_q),
        .txe      (txe_q),
        .dat_r    (dat_r),
        .ready    (ready),
        .ready_rst(ready_rst_q)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_w_d     = dat_w_q;
        gap_d       = gap_q;
        dat_t_d     = dat_t_q;
        txe_d       = 1'b0;
        ready_rst_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
        to_d        = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                // ready stays high for the cycle the flush pulse is in flight
                if (ready && !ready_rst_q) ready_rst_d = 1'b1;
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_w_d = cmd_dat_w;
                    busy_d  = 1'b1;
                    state_d = S_TX_ADDR;
                end
            end
            S_TX_ADDR: begin
                dat_t_d = addr_byte(we_q, adr_q);
                txe_d   = 1'b1;
                gap_d   = GAP_LOAD;
                state_d = S_GAP_A;
            end
            S_GAP_A, S_GAP_D: begin
                if (gap_q == '0) begin
                    if (state_q == S_GAP_A && we_q) begin
                        state_d = S_TX_DATA;
                    end else begin
                        state_d = S_WAIT_RSP;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
                        to_d    = TO_LOAD;
`endif
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_TX_DATA: begin
                dat_t_d = dat_w_q;
                txe_d   = 1'b1;
                gap_d   = GAP_LOAD;
                state_d = S_GAP_D;
            end
            S_WAIT_RSP: begin
                if (ready) begin
                    ready_rst_d = 1'b1;
                    rsp_dat_d   = dat_r;
                    rsp_err_d   = we_q && (dat_r != dat_w_q);
                    state_d     = S_RESP;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
                end else if (to_q == 16'd0) begin
                    rsp_dat_d = 8'hFF;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    to_d = to_q - 16'd1;
`endif
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            gap_q       <= '0;
            dat_t_q     <= '0;
            txe_q       <= 1'b0;
            ready_rst_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_w_q     <= dat_w_d;
            gap_q       <= gap_d;
            dat_t_q     <= dat_t_d;
            txe_q       <= txe_d;
            ready_rst_q <= ready_rst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    // Held low while reset is asserted even though the state already reads IDLE.
    assign cmd_ready = rst && (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_csr_serial_master.sv
// Directed bench for csr_serial_master: table of read/write transactions with a
// bit-level responder and line decoder, plus hand-written corner sequences.
module tb_csr_serial_master;

    localparam int TX_GAP      = 110;
    localparam int RSP_TIMEOUT = 100;
    localparam int CPB         = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_rx = 1'b1;
    logic       serial_tx;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [6:0] cmd_adr = '0;
    logic [7:0] cmd_dat_w = '0;
    logic       rsp_valid;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic       busy;

    csr_serial_master #(
        .TX_GAP     (TX_GAP),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .serial_rx(serial_rx),
        .serial_tx(serial_tx),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat_w(cmd_dat_w),
        .rsp_valid(rsp_valid),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Line decoder: start bit detected at a negedge, bits sampled mid-period.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge clk);
            if (rst && serial_tx == 1'b0) begin
                t0 = cyc;
                repeat (CPB + CPB / 2) @(negedge clk);
                b[0] = serial_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = serial_tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    int         rsp_cnt = 0;
    int         rsp_cyc = 0;
    logic [7:0] last_dat = '0;
    logic       last_err = 1'b0;
    int         acc_cnt = 0;
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc  = cyc;
            last_dat = rsp_dat;
            last_err = rsp_err;
        end
        if (cmd_valid && cmd_ready) acc_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 serial_rx = frame[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 serial_rx = 1'b1;
    endtask

    task automatic issue(input logic we, input logic [6:0] adr, input logic [7:0] dat);
        int start;
        start = acc_cnt;
        @(posedge clk);
        #1;
        cmd_we = we; cmd_adr = adr; cmd_dat_w = dat; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_cnt > start) break;
        end
        #1 cmd_valid = 1'b0;
        chk("accept", 32'(acc_cnt - start), 32'd1);
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() >= n) break;
            @(posedge clk);
        end
        chk("line_byte_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_rsp(input int n0, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rsp_cnt > n0) break;
            @(posedge clk);
        end
        chk("rsp_count", 32'(rsp_cnt), 32'(n0 + 1));
    endtask

    typedef struct {
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat;
        logic [7:0] reply;
        logic [7:0] exp_b0;
        logic [7:0] exp_b1;
        logic [7:0] exp_dat;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0, a0, r1;
        vecs[0] = '{we: 1'b0, adr: 7'h12, dat: 8'hEE, reply: 8'h5A, exp_b0: 8'h12, exp_b1: 8'h00, exp_dat: 8'h5A, exp_err: 1'b0};
        vecs[1] = '{we: 1'b1, adr: 7'h05, dat: 8'hC3, reply: 8'hC3, exp_b0: 8'h85, exp_b1: 8'hC3, exp_dat: 8'hC3, exp_err: 1'b0};
        vecs[2] = '{we: 1'b1, adr: 7'h05, dat: 8'hC3, reply: 8'h00, exp_b0: 8'h85, exp_b1: 8'hC3, exp_dat: 8'h00, exp_err: 1'b1};
        vecs[3] = '{we: 1'b0, adr: 7'h7F, dat: 8'h00, reply: 8'h00, exp_b0: 8'h7F, exp_b1: 8'h00, exp_dat: 8'h00, exp_err: 1'b0};
        vecs[4] = '{we: 1'b1, adr: 7'h00, dat: 8'hFF, reply: 8'hFF, exp_b0: 8'h80, exp_b1: 8'hFF, exp_dat: 8'hFF, exp_err: 1'b0};
        vecs[5] = '{we: 1'b1, adr: 7'h7F, dat: 8'h01, reply: 8'h80, exp_b0: 8'hFF, exp_b1: 8'h01, exp_dat: 8'h80, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_dat", 32'(rsp_dat), 32'h00);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_serial_tx", 32'(serial_tx), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            rx_q.delete(); rx_t.delete();
            n0 = rsp_cnt;
            issue(vecs[v].we, vecs[v].adr, vecs[v].dat);
            chk("busy_after_accept", 32'(busy), 32'd1);
            chk("ready_low_when_busy", 32'(cmd_ready), 32'd0);
            wait_bytes(vecs[v].we ? 2 : 1);
            if (rx_q.size() >= 1) chk("addr_byte", 32'(rx_q[0]), 32'(vecs[v].exp_b0));
            if (vecs[v].we && rx_q.size() >= 2) begin
                chk("data_byte", 32'(rx_q[1]), 32'(vecs[v].exp_b1));
                chk("txe_spacing", 32'(rx_t[1] - rx_t[0]), 32'(TX_GAP + 1));
            end
            send_byte(vecs[v].reply);
            wait_rsp(n0, 500);
            chk("rsp_dat", 32'(last_dat), 32'(vecs[v].exp_dat));
            chk("rsp_err", 32'(last_err), 32'(vecs[v].exp_err));
            repeat (5) @(posedge clk);
            chk("rsp_dat_hold", 32'(rsp_dat), 32'(vecs[v].exp_dat));
            chk("busy_done", 32'(busy), 32'd0);
            chk("single_rsp", 32'(rsp_cnt), 32'(n0 + 1));
            $display("txn %0d: we=%0d adr=%02h dat=%02h reply=%02h -> rsp_dat=%02h rsp_err=%0d",
                     v, vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].reply, last_dat, last_err);
        end

        // Stale byte in IDLE must be flushed, not returned as the next reply.
        n0 = rsp_cnt;
        send_byte(8'h33);
        repeat (20) @(posedge clk);
        chk("stale_no_rsp", 32'(rsp_cnt), 32'(n0));
        rx_q.delete(); rx_t.delete();
        issue(1'b0, 7'h21, 8'h00);
        wait_bytes(1);
        if (rx_q.size() >= 1) chk("stale_addr_byte", 32'(rx_q[0]), 32'h21);
        send_byte(8'h44);
        wait_rsp(n0, 500);
        chk("stale_rsp_dat", 32'(last_dat), 32'h44);
        chk("stale_rsp_err", 32'(last_err), 32'd0);
        $display("txn stale: flushed 33, read adr=21 -> rsp_dat=%02h", last_dat);

        // cmd_valid held across two transactions: one accept per response.
        repeat (5) @(posedge clk);
        n0 = rsp_cnt; a0 = acc_cnt;
        rx_q.delete(); rx_t.delete();
        @(posedge clk);
        #1 cmd_we = 1'b0; cmd_adr = 7'h10; cmd_valid = 1'b1;
        wait_bytes(1);
        send_byte(8'h01);
        wait_rsp(n0, 500);
        r1 = rsp_cyc;
        chk("bp_first_dat", 32'(last_dat), 32'h01);
        wait_bytes(2);
        #1 cmd_valid = 1'b0;
        // rsp_valid edge R -> accept R+1 -> txe R+2 -> start bit R+3
        if (rx_t.size() >= 2) chk("bp_second_txe_lat", 32'(rx_t[1] - r1), 32'd3);
        if (rx_q.size() >= 2) chk("bp_second_addr", 32'(rx_q[1]), 32'h10);
        send_byte(8'h02);
        wait_rsp(n0 + 1, 500);
        chk("bp_second_dat", 32'(last_dat), 32'h02);
        repeat (5) @(posedge clk);
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        $display("txn backpressure: two reads adr=10 -> %0d accepts, last rsp_dat=%02h", acc_cnt - a0, last_dat);

`ifdef CSR_SERIAL_MASTER_TIMEOUT_EN
        repeat (5) @(posedge clk);
        n0 = rsp_cnt;
        rx_q.delete(); rx_t.delete();
        issue(1'b0, 7'h22, 8'h00);
        wait_bytes(1);
        wait_rsp(n0, 1000);
        chk("timeout_rsp_dat", 32'(last_dat), 32'hFF);
        chk("timeout_rsp_err", 32'(last_err), 32'd1);
        // WAIT_RSP starts TX_GAP-1 after the start bit; expiry + latch + RESP adds 102.
        if (rx_t.size() >= 1) begin
            checks++;
            if ((rsp_cyc - rx_t[0]) < (TX_GAP + 100) || (rsp_cyc - rx_t[0]) > (TX_GAP + 102)) begin
                errors++;
                $display("FAIL timeout_latency: got %0d expected %0d..%0d",
                         rsp_cyc - rx_t[0], TX_GAP + 100, TX_GAP + 102);
            end
        end
        $display("txn timeout: read adr=22 no reply -> rsp_dat=%02h rsp_err=%0d", last_dat, last_err);
`endif

        // Reset in the middle of the address gap: back to IDLE, no response.
        repeat (5) @(posedge clk);
        n0 = rsp_cnt;
        issue(1'b0, 7'h33, 8'h00);
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (300) @(posedge clk);
        chk("midrst_no_rsp", 32'(rsp_cnt), 32'(n0));
        chk("midrst_idle_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy_after", 32'(busy), 32'd0);
        chk("midrst_line_idle", 32'(serial_tx), 32'd1);
        $display("txn reset: read adr=33 aborted in gap, responses=%0d", rsp_cnt - n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
